// File: rtl/spm_seq_mul.sv
// spm_seq_mul: serial-parallel multiplier with start/done handshake.
//
// The multiplicand is held in parallel, the multiplier is shifted in LSB-first,
// and the 2*WIDTH-bit product comes out serially LSB-first (p_serial/p_valid).
// It is also assembled into a parallel register (product). One result every
// 2*WIDTH+1 cycles when start is held high. Unsigned or two's-complement signed
// operation is selected per operation; the signed path is only built when
// SIGNED_EN=1.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (overrides clr and start)
//   clr          synchronous abort back to IDLE (clears product and the CSA)
//   start        operation request, taken when ready=1
//   signed_mode  1 = two's-complement operands, latched on accepted start
//   multiplicand parallel operand x, latched on accepted start
//   multiplier   operand y, latched on accepted start and serialised
//   ready        high in IDLE and DONE
//   busy         high in RUN
//   p_serial     current product bit, LSB-first
//   p_valid      qualifies p_serial
//   product      parallel product, updated at the RUN->DONE edge
//   done         one-cycle pulse when product is valid
module spm_seq_mul #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 busy,
  output logic                 p_serial,
  output logic                 p_valid,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(PW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  x_q;
  logic [WIDTH-1:0]  y_sr_q, y_sr_d;
  logic              mode_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [WIDTH-1:0]  carry_q, carry_d;
  logic [PW-1:0]     prod_sr_q, prod_sr_d;
  logic [PW-1:0]     product_q;

  logic [WIDTH-1:0]  pp;
  logic [WIDTH-1:0]  sin;
  logic [WIDTH-1:0]  fa_s;
  logic [WIDTH-1:0]  fa_c;
  logic              last_run;

  // Carry-save array. Each cycle stage k adds partial-product bit k, the sum
  // from stage k+1 (right shift) and its own stored carry; stage 0's sum is
  // the product bit leaving this cycle.
  // Signed mode: the top stage adds (1 - x[W-1]&ybit) instead of the negative
  // weight -x[W-1]&ybit. The constant +2^(W-1) this adds every cycle sums to
  // -2^(W-1) mod 2^(2W), cancelled by injecting one +2^(W-1) into the top
  // stage on the first RUN cycle (its sum input is otherwise always 0).
  always_comb begin
    pp  = '0;
    sin = sum_q;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      pp[k] = x_q[k] & y_sr_q[0];
    end
    if (mode_q) begin
      pp[WIDTH-1]  = ~pp[WIDTH-1];
      sin[WIDTH-1] = sum_q[WIDTH-1] | (cnt_q == '0);
    end
    fa_s      = pp ^ sin ^ carry_q;
    fa_c      = (pp & sin) | (pp & carry_q) | (sin & carry_q);
    sum_d     = {1'b0, fa_s[WIDTH-1:1]};
    carry_d   = fa_c;
    // Sign-extend the multiplier in signed mode, zero-fill otherwise.
    y_sr_d    = {mode_q & y_sr_q[WIDTH-1], y_sr_q[WIDTH-1:1]};
    prod_sr_d = {fa_s[0], prod_sr_q[PW-1:1]};
  end

  assign last_run = (cnt_q == CW'(PW - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q   <= S_IDLE;
      x_q       <= '0;
      y_sr_q    <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      sum_q     <= '0;
      carry_q   <= '0;
      prod_sr_q <= '0;
      product_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q   <= S_RUN;
            x_q       <= multiplicand;
            y_sr_q    <= multiplier;
            mode_q    <= signed_mode & SIGNED_EN;
            cnt_q     <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            prod_sr_q <= '0;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          y_sr_q    <= y_sr_d;
          sum_q     <= sum_d;
          carry_q   <= carry_d;
          prod_sr_q <= prod_sr_d;
          cnt_q     <= cnt_q + 1'b1;
          if (last_run) begin
            state_q   <= S_DONE;
            product_q <= prod_sr_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign busy     = (state_q == S_RUN);
  assign p_valid  = (state_q == S_RUN);
  assign p_serial = (state_q == S_RUN) & fa_s[0];
  assign done     = (state_q == S_DONE);
  assign product  = product_q;

endmodule

// File: doc/spm_seq_mul.md
Name: spm_seq_mul

Overview:
- Parameterised serial-parallel multiplier with its own control FSM and start/done handshake.
- Multiplicand is held in parallel. Multiplier is shifted in LSB-first. Product is produced serially LSB-first and also assembled into a parallel register.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Sits between a register-interface/control block and the datapath consumer, which can use either the serial stream or the parallel result.

Parameters:
- WIDTH, 8, operand width in bits. Must be ≥ 2. Product width is 2*WIDTH.
- SIGNED_EN, 1, when 0 the signed path is not built and signed_mode is ignored (always unsigned).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous abort. Returns the block to IDLE. Lower priority than rst.
- start  input  1  operation request, sampled when ready=1.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned. Latched on accepted start.
- multiplicand  input  WIDTH  parallel operand x. Latched on accepted start.
- multiplier  input  WIDTH  operand y. Latched on accepted start, then serialised internally.
- ready  output  1  high in IDLE and DONE.
- busy  output  1  high in RUN.
- p_serial  output  1  current product bit, LSB-first.
- p_valid  output  1  qualifies p_serial.
- product  output  2*WIDTH  parallel product. Stable while ready=1.
- done  output  1  one-cycle pulse when product is valid.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - ready=1, busy=0, done=0, p_valid=0, p_serial=0, product=0.
  - All CSA sum/carry flops cleared.
  - Overrides clr and start.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start=1.
  - RUN→DONE after exactly 2*WIDTH RUN cycles.
  - DONE→RUN on start=1.
  - DONE→IDLE on start=0.
- Accepted start:
  - Latches multiplicand, multiplier and the effective mode. Effective mode is signed_mode & SIGNED_EN.
  - Clears the CSA array, the bit counter and the product shift register in the same edge.
- start while busy=1 is ignored. Operands and mode are not re-latched.
- RUN, on each cycle i = 0..2*WIDTH-1:
  - Serial multiplier bit is y_sr[0]. y_sr shifts right each cycle.
  - Fill bit is y_sr[WIDTH-1] (sign extension) in signed mode, 0 in unsigned mode.
  - Stage k (k < WIDTH-1) adds x[k]&ybit as a normal carry-save stage.
  - Top stage (k = WIDTH-1): in signed mode it contributes the two's-complement weight of x[WIDTH-1]&ybit. In unsigned mode it is a normal CSA stage.
  - p_valid=1 and p_serial = bit i of the exact 2*WIDTH-bit product.
  - Bit i is shifted into product[i]. The visible product register updates only at the RUN→DONE edge.
- Latency:
  - Start is accepted at edge E. p_valid is high for cycles E+1..E+2*WIDTH.
  - done=1 and the new product is visible in cycle E+2*WIDTH+1.
  - One result every 2*WIDTH+1 cycles when back-to-back.
- DONE:
  - done=1 for exactly one cycle. p_valid=0.
  - product holds its value until the next accepted start completes, or until rst or clr.
- Arithmetic: result is the exact product modulo 2^(2*WIDTH).
  - Unsigned: product = x*y.
  - Signed: product = sx*sy, two's complement, no overflow possible.
- clr=1 (with rst=0):
  - Any state → IDLE next cycle. product=0, done=0, p_valid=0, CSA cleared.
  - Applies in IDLE, RUN or DONE.
  - Simultaneous clr and start: clr wins, start is not accepted.
- Mode or operand input changes during RUN have no effect.

Test Plan:
- WIDTH=8, unsigned, 255×255 → product=0xFE01. Serial stream LSB-first equals 0xFE01. done at start edge + 17.
- WIDTH=8, signed, −128×−128 → product=0x4000. Signed −3×5 → product=0xFFF1. Same operands (0x80×0x80) in unsigned mode → product=0x4000; (0xFD×0x05) unsigned → product=0x04F1.
- Back-to-back: start held high in DONE with 12×10, then 7×6 → two done pulses 17 cycles apart. product=120, then 42. No idle cycle between.
- start pulsed mid-RUN with different operands → ignored. Original result completes. busy stays high exactly 16 cycles.
- rst asserted at RUN cycle 5 → next cycle ready=1, product=0, no done pulse. Then clr at RUN cycle 3 of a new operation → same return to IDLE. A subsequent 9×9 yields 81.
- WIDTH=4 instance: signed −8×7 → product=0xC8, done at start edge + 9. SIGNED_EN=0 instance with signed_mode=1, 0xF×0xF → 0xE1 (unsigned).
